// File: rtl/mips_control_fsm.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/write-back
// for add/sub/and/xor, addi, lw, sw, beq, bne and j.
// Optional exception handling is compiled in with `define MIPS_EXCEPTION_EN.
// Every output is registered alongside the state, except PC_load, which also
// carries the combinational branch decision in BRANCH.
module mips_control_fsm (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       ALU_zero,
    input  logic       ALU_overflow,
    output logic       PC_load,
    output logic       IorD,
    output logic       wr,
    output logic       IR_load,
    output logic       MDR_load,
    output logic       A_load,
    output logic       B_load,
    output logic       ALUOut_load,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALU_sel,
    output logic [1:0] PCSource,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       EPC_load,
    output logic [4:0] State
);

    localparam int unsigned STATE_W = 5;
    localparam int unsigned FIELD_W = 6;

    localparam logic [FIELD_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [FIELD_W-1:0] OP_J     = 6'h02;
    localparam logic [FIELD_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [FIELD_W-1:0] OP_BNE   = 6'h05;
    localparam logic [FIELD_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [FIELD_W-1:0] OP_LW    = 6'h23;
    localparam logic [FIELD_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FIELD_W-1:0] FN_ADD = 6'h20;
    localparam logic [FIELD_W-1:0] FN_SUB = 6'h22;
    localparam logic [FIELD_W-1:0] FN_AND = 6'h24;
    localparam logic [FIELD_W-1:0] FN_XOR = 6'h26;

    typedef enum logic [STATE_W-1:0] {
        S_RESET     = 5'd0,
        S_FETCH     = 5'd1,
        S_IR_WAIT   = 5'd2,
        S_DECODE    = 5'd3,
        S_MEM_ADDR  = 5'd4,
        S_LW_READ   = 5'd5,
        S_LW_WAIT   = 5'd6,
        S_LW_WB     = 5'd7,
        S_SW_WRITE  = 5'd8,
        S_R_EXEC    = 5'd9,
        S_R_WB      = 5'd10,
        S_ADDI_EXEC = 5'd11,
        S_ADDI_WB   = 5'd12,
        S_BRANCH    = 5'd13,
        S_JUMP      = 5'd14,
        S_EXC_EPC   = 5'd15,
        S_EXC_JUMP  = 5'd16
    } state_t;

    typedef struct packed {
        logic       pc_load;
        logic       iord;
        logic       wr;
        logic       ir_load;
        logic       mdr_load;
        logic       a_load;
        logic       b_load;
        logic       aluout_load;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_sel;
        logic [1:0] pc_source;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       epc_load;
    } ctrl_t;

`ifdef MIPS_EXCEPTION_EN
    localparam state_t UNDEF_NEXT = S_EXC_EPC;
`else
    localparam state_t UNDEF_NEXT = S_FETCH;
    // Overflow has no effect without exception support.
    logic unused_ovf;
    assign unused_ovf = ALU_overflow;
`endif

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_d;
    logic   funct_valid_c;
    logic   funct_arith_c;
    logic   branch_take_c;
    logic [2:0] r_alu_sel_c;

    // Funct classification and R-type ALU operation select.
    always_comb begin
        funct_valid_c = 1'b1;
        funct_arith_c = 1'b0;
        r_alu_sel_c   = 3'b000;
        case (Funct)
            FN_ADD:  begin r_alu_sel_c = 3'b001; funct_arith_c = 1'b1; end
            FN_SUB:  begin r_alu_sel_c = 3'b010; funct_arith_c = 1'b1; end
            FN_AND:  r_alu_sel_c = 3'b011;
            FN_XOR:  r_alu_sel_c = 3'b110;
            default: funct_valid_c = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:   state_d = S_FETCH;
            S_FETCH:   state_d = S_IR_WAIT;
            S_IR_WAIT: state_d = S_DECODE;
            S_DECODE: begin
                state_d = UNDEF_NEXT;
                case (Opcode)
                    OP_RTYPE:     if (funct_valid_c) state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    OP_BEQ,
                    OP_BNE:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = UNDEF_NEXT;
                endcase
            end
            S_MEM_ADDR: state_d = (Opcode == OP_SW) ? S_SW_WRITE : S_LW_READ;
            S_LW_READ:  state_d = S_LW_WAIT;
            S_LW_WAIT:  state_d = S_LW_WB;
            S_LW_WB:    state_d = S_FETCH;
            S_SW_WRITE: state_d = S_FETCH;
            S_R_EXEC: begin
                state_d = S_R_WB;
`ifdef MIPS_EXCEPTION_EN
                if (ALU_overflow && funct_arith_c) state_d = S_EXC_EPC;
`endif
            end
            S_R_WB:     state_d = S_FETCH;
            S_ADDI_EXEC: begin
                state_d = S_ADDI_WB;
`ifdef MIPS_EXCEPTION_EN
                if (ALU_overflow) state_d = S_EXC_EPC;
`endif
            end
            S_ADDI_WB:  state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
`ifdef MIPS_EXCEPTION_EN
            S_EXC_EPC:  state_d = S_EXC_JUMP;
            S_EXC_JUMP: state_d = S_FETCH;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // Output decode for the state being entered, so outputs register with it.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_FETCH: begin
                ctrl_d.alu_src_b = 2'b01;
                ctrl_d.alu_sel   = 3'b001;
                ctrl_d.pc_load   = 1'b1;
            end
            S_IR_WAIT: ctrl_d.ir_load = 1'b1;
            S_DECODE: begin
                ctrl_d.a_load      = 1'b1;
                ctrl_d.b_load      = 1'b1;
                ctrl_d.alu_src_b   = 2'b11;
                ctrl_d.alu_sel     = 3'b001;
                ctrl_d.aluout_load = 1'b1;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl_d.alu_src_a   = 1'b1;
                ctrl_d.alu_src_b   = 2'b10;
                ctrl_d.alu_sel     = 3'b001;
                ctrl_d.aluout_load = 1'b1;
            end
            S_LW_READ: ctrl_d.iord = 1'b1;
            S_LW_WAIT: begin
                ctrl_d.iord     = 1'b1;
                ctrl_d.mdr_load = 1'b1;
            end
            S_LW_WB: begin
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.reg_write  = 1'b1;
            end
            S_SW_WRITE: begin
                ctrl_d.iord = 1'b1;
                ctrl_d.wr   = 1'b1;
            end
            S_R_EXEC: begin
                ctrl_d.alu_src_a   = 1'b1;
                ctrl_d.alu_sel     = r_alu_sel_c;
                ctrl_d.aluout_load = 1'b1;
            end
            S_R_WB: begin
                ctrl_d.reg_dst   = 1'b1;
                ctrl_d.reg_write = 1'b1;
            end
            S_ADDI_WB: ctrl_d.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_sel   = 3'b010;
                ctrl_d.pc_source = 2'b01;
            end
            S_JUMP: begin
                ctrl_d.pc_source = 2'b10;
                ctrl_d.pc_load   = 1'b1;
            end
`ifdef MIPS_EXCEPTION_EN
            S_EXC_EPC: begin
                ctrl_d.alu_src_b = 2'b01;
                ctrl_d.alu_sel   = 3'b010;
                ctrl_d.epc_load  = 1'b1;
            end
            S_EXC_JUMP: begin
                ctrl_d.pc_source = 2'b11;
                ctrl_d.pc_load   = 1'b1;
            end
`endif
            default: ctrl_d = '0;
        endcase
    end

    // State and output registers; reset aborts any instruction in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_RESET;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Branch decision: beq takes on zero, bne on non-zero.
    assign branch_take_c = (state_q == S_BRANCH) &&
                           ((Opcode == OP_BEQ) ? ALU_zero : ~ALU_zero);

    assign PC_load     = ctrl_q.pc_load | branch_take_c;
    assign IorD        = ctrl_q.iord;
    assign wr          = ctrl_q.wr;
    assign IR_load     = ctrl_q.ir_load;
    assign MDR_load    = ctrl_q.mdr_load;
    assign A_load      = ctrl_q.a_load;
    assign B_load      = ctrl_q.b_load;
    assign ALUOut_load = ctrl_q.aluout_load;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALU_sel     = ctrl_q.alu_sel;
    assign PCSource    = ctrl_q.pc_source;
    assign RegDst      = ctrl_q.reg_dst;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign RegWrite    = ctrl_q.reg_write;
    assign EPC_load    = ctrl_q.epc_load;
    assign State       = state_q;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Scoreboard bench for mips_control_fsm: stimulus queues the expected state and
// control word for each cycle, a negedge monitor pops and compares.
module tb_mips_control_fsm;

    typedef struct packed {
        logic       pc_load;
        logic       iord;
        logic       wr;
        logic       ir_load;
        logic       mdr_load;
        logic       a_load;
        logic       b_load;
        logic       aluout_load;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_sel;
        logic [1:0] pc_source;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       epc_load;
    } ctrl_t;

    typedef struct packed {
        logic [4:0] st;
        ctrl_t      c;
    } exp_t;

    localparam logic [4:0] ST_RESET = 5'd0,  ST_FETCH = 5'd1,  ST_IRW  = 5'd2,
                           ST_DEC   = 5'd3,  ST_MEMA  = 5'd4,  ST_LWR  = 5'd5,
                           ST_LWW   = 5'd6,  ST_LWWB  = 5'd7,  ST_SW   = 5'd8,
                           ST_REX   = 5'd9,  ST_RWB   = 5'd10, ST_AEX  = 5'd11,
                           ST_AWB   = 5'd12, ST_BR    = 5'd13, ST_JMP  = 5'd14,
                           ST_EEPC  = 5'd15, ST_EJMP  = 5'd16;

    logic       Clk;
    logic       Reset_n;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       ALU_zero;
    logic       ALU_overflow;
    logic       PC_load, IorD, wr, IR_load, MDR_load, A_load, B_load, ALUOut_load;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALU_sel;
    logic [1:0] PCSource;
    logic       RegDst, MemtoReg, RegWrite, EPC_load;
    logic [4:0] State;

    exp_t       sb[$];
    logic [4:0] seq[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    mips_control_fsm dut (
        .Clk(Clk), .Reset_n(Reset_n), .Opcode(Opcode), .Funct(Funct),
        .ALU_zero(ALU_zero), .ALU_overflow(ALU_overflow),
        .PC_load(PC_load), .IorD(IorD), .wr(wr), .IR_load(IR_load),
        .MDR_load(MDR_load), .A_load(A_load), .B_load(B_load),
        .ALUOut_load(ALUOut_load), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALU_sel(ALU_sel), .PCSource(PCSource), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .EPC_load(EPC_load),
        .State(State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Hand-entered control word per state, straight from the state table.
    function automatic ctrl_t exp_ctrl(input logic [4:0] s, input logic [5:0] op,
                                       input logic [5:0] fn, input logic z);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin c.alu_src_b = 2'b01; c.alu_sel = 3'b001; c.pc_load = 1'b1; end
            ST_IRW:   c.ir_load = 1'b1;
            ST_DEC:   begin c.a_load = 1'b1; c.b_load = 1'b1; c.alu_src_b = 2'b11;
                            c.alu_sel = 3'b001; c.aluout_load = 1'b1; end
            ST_MEMA, ST_AEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                            c.alu_sel = 3'b001; c.aluout_load = 1'b1; end
            ST_LWR:   c.iord = 1'b1;
            ST_LWW:   begin c.iord = 1'b1; c.mdr_load = 1'b1; end
            ST_LWWB:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
            ST_SW:    begin c.iord = 1'b1; c.wr = 1'b1; end
            ST_REX:   begin
                c.alu_src_a = 1'b1; c.aluout_load = 1'b1;
                case (fn)
                    6'h20: c.alu_sel = 3'b001;
                    6'h22: c.alu_sel = 3'b010;
                    6'h24: c.alu_sel = 3'b011;
                    6'h26: c.alu_sel = 3'b110;
                    default: c.alu_sel = 3'b000;
                endcase
            end
            ST_RWB:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
            ST_AWB:   c.reg_write = 1'b1;
            ST_BR:    begin c.alu_src_a = 1'b1; c.alu_sel = 3'b010; c.pc_source = 2'b01;
                            c.pc_load = (op == 6'h04) ? z : ~z; end
            ST_JMP:   begin c.pc_source = 2'b10; c.pc_load = 1'b1; end
            ST_EEPC:  begin c.alu_src_b = 2'b01; c.alu_sel = 3'b010; c.epc_load = 1'b1; end
            ST_EJMP:  begin c.pc_source = 2'b11; c.pc_load = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    // Queue the expectation for the current cycle, then advance one clock.
    task automatic step(input logic [4:0] s);
        exp_t e;
        e.st = s;
        e.c  = exp_ctrl(s, Opcode, Funct, ALU_zero);
        sb.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    // Run one instruction whose state sequence is in seq, starting in FETCH.
    task automatic run(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic ov);
        Opcode = op; Funct = fn; ALU_zero = z; ALU_overflow = ov;
        foreach (seq[i]) step(seq[i]);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation.
    always @(negedge Clk) begin
        exp_t  e;
        ctrl_t act;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {PC_load, IorD, wr, IR_load, MDR_load, A_load, B_load, ALUOut_load,
                   ALUSrcA, ALUSrcB, ALU_sel, PCSource, RegDst, MemtoReg, RegWrite,
                   EPC_load};
            n_cmp = n_cmp + 1;
            if (State !== e.st) begin
                n_bad = n_bad + 1;
                $display("FAIL state @%0t: got %0d want %0d", $time, State, e.st);
            end
            n_cmp = n_cmp + 1;
            if (act !== e.c) begin
                n_bad = n_bad + 1;
                $display("FAIL outputs in state %0d @%0t: got %05h want %05h",
                         e.st, $time, act, e.c);
            end
        end
    end

    initial begin
        Reset_n = 1'b1; Opcode = 6'h00; Funct = 6'h20; ALU_zero = 1'b0; ALU_overflow = 1'b0;
        #2 Reset_n = 1'b0;
        @(posedge Clk); #1;
        step(ST_RESET);                     // held in reset across an edge
        Reset_n = 1'b1;
        step(ST_RESET);                     // released, first edge enters FETCH

        seq = '{ST_FETCH, ST_IRW, ST_DEC, ST_MEMA, ST_LWR, ST_LWW, ST_LWWB};
        run(6'h23, 6'h00, 1'b0, 1'b0);      // lw
        seq = '{ST_FETCH, ST_IRW, ST_DEC, ST_MEMA, ST_SW};
        run(6'h2B, 6'h00, 1'b0, 1'b0);      // sw
        seq = '{ST_FETCH, ST_IRW, ST_DEC, ST_BR};
        run(6'h04, 6'h00, 1'b1, 1'b0);      // beq taken
        run(6'h05, 6'h00, 1'b1, 1'b0);      // bne not taken
        run(6'h04, 6'h00, 1'b0, 1'b0);      // beq not taken
        run(6'h05, 6'h00, 1'b0, 1'b0);      // bne taken
        seq = '{ST_FETCH, ST_IRW, ST_DEC, ST_REX, ST_RWB};
        run(6'h00, 6'h26, 1'b0, 1'b0);      // xor
        run(6'h00, 6'h20, 1'b0, 1'b0);      // add
        run(6'h00, 6'h22, 1'b1, 1'b0);      // sub
        run(6'h00, 6'h24, 1'b0, 1'b0);      // and
        seq = '{ST_FETCH, ST_IRW, ST_DEC, ST_AEX, ST_AWB};
        run(6'h08, 6'h00, 1'b0, 1'b0);      // addi
        seq = '{ST_FETCH, ST_IRW, ST_DEC, ST_JMP};
        run(6'h02, 6'h00, 1'b0, 1'b0);      // j

        // Reset asserted mid-R_EXEC aborts the instruction.
        seq = '{ST_FETCH, ST_IRW, ST_DEC};
        run(6'h00, 6'h20, 1'b0, 1'b0);
        begin
            exp_t e;
            e.st = ST_REX; e.c = exp_ctrl(ST_REX, Opcode, Funct, ALU_zero);
            sb.push_back(e);
            @(negedge Clk); #1;
            Reset_n = 1'b0;
            e.st = ST_RESET; e.c = '0;
            sb.push_back(e);                // checked at the next negedge, reset low
            @(negedge Clk); #1;
            Reset_n = 1'b1;
            @(posedge Clk); #1;             // first edge after release: FETCH
        end

`ifdef MIPS_EXCEPTION_EN
        seq = '{ST_FETCH, ST_IRW, ST_DEC, ST_EEPC, ST_EJMP};
        run(6'h3F, 6'h00, 1'b0, 1'b0);      // undefined opcode
        run(6'h00, 6'h15, 1'b0, 1'b0);      // undefined funct
        seq = '{ST_FETCH, ST_IRW, ST_DEC, ST_REX, ST_EEPC, ST_EJMP};
        run(6'h00, 6'h20, 1'b0, 1'b1);      // add overflow
        seq = '{ST_FETCH, ST_IRW, ST_DEC, ST_AEX, ST_EEPC, ST_EJMP};
        run(6'h08, 6'h00, 1'b0, 1'b1);      // addi overflow
        seq = '{ST_FETCH, ST_IRW, ST_DEC, ST_REX, ST_RWB};
        run(6'h00, 6'h24, 1'b0, 1'b1);      // and ignores overflow
`else
        seq = '{ST_FETCH, ST_IRW, ST_DEC};
        run(6'h3F, 6'h00, 1'b0, 1'b0);      // undefined opcode is a NOP
        run(6'h00, 6'h15, 1'b0, 1'b0);      // undefined funct is a NOP
        seq = '{ST_FETCH, ST_IRW, ST_DEC, ST_REX, ST_RWB};
        run(6'h00, 6'h20, 1'b0, 1'b1);      // overflow ignored
        seq = '{ST_FETCH, ST_IRW, ST_DEC, ST_AEX, ST_AWB};
        run(6'h08, 6'h00, 1'b0, 1'b1);
`endif
        seq = '{ST_FETCH, ST_IRW, ST_DEC, ST_JMP};
        run(6'h02, 6'h00, 1'b0, 1'b0);

        @(negedge Clk); #1;
        n_cmp = n_cmp + 1;
        if (sb.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL scoreboard drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
